// File: rtl/bufmr_seq_pkg.sv
// bufmr_ce_sequencer shared types and limits.
// State encoding, counter width and parameter ranges.
package bufmr_seq_pkg;

  localparam int CNT_W    = 8;
  localparam int CYC_MIN  = 1;
  localparam int CYC_MAX  = 255;
  localparam int BUFR_MIN = 1;
  localparam int BUFR_MAX = 8;

  typedef enum logic [2:0] {
    ST_HALT   = 3'd0,
    ST_CE_OFF = 3'd1,
    ST_CLR    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RUN    = 3'd4
  } state_e;

  function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/bufmr_ce_sequencer_sync_2ff.sv
// Generic two-flop synchronizer, async active-low reset.
// Used for the lock input when BUFMR_SEQ_LOCK_SYNC_EN is defined.
module sync_2ff #(
  parameter int   W       = 1,
  parameter logic RST_VAL = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  // two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= {W{RST_VAL}};
      s2_q <= {W{RST_VAL}};
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/bufmr_ce_sequencer.sv
// BUFMR CE / BUFR CLR stop-clear-release-restart sequencer.
// Define BUFMR_SEQ_LOCK_SYNC_EN to pass locked through a 2-flop sync.
module bufmr_ce_sequencer
  import bufmr_seq_pkg::*;
#(
  parameter int CE_OFF_CYCLES = 4,
  parameter int CLR_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int NUM_BUFR      = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                locked,
  input  logic                resync_req,
  output logic                resync_ack,
  output logic                ce_out,
  output logic [NUM_BUFR-1:0] bufr_clr,
  output logic                clk_ready,
  output logic                busy
);

  logic lk;

`ifdef BUFMR_SEQ_LOCK_SYNC_EN
  sync_2ff #(.W(1), .RST_VAL(1'b0)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (lk)
  );
`else
  assign lk = locked;
`endif

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic                  ack_q, ack_d;
  logic                  ce_q, ce_d;
  logic [NUM_BUFR-1:0]   clr_q, clr_d;
  logic                  rdy_q, rdy_d;
  logic                  busy_q, busy_d;

  // state, counter, pending flag and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HALT;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      ce_q    <= 1'b0;
      clr_q   <= '1;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      ce_q    <= ce_d;
      clr_q   <= clr_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  // next state; outputs decoded from the next state so they flip
  // on the same edge as the transition
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ack_d   = 1'b0;
    if (state_q != ST_HALT && !lk) begin
      state_d = ST_HALT;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_HALT: begin
          if (lk) begin
            state_d = ST_CE_OFF;
            cnt_d   = cnt_load(CE_OFF_CYCLES);
          end
        end
        ST_CE_OFF: begin
          if (cnt_q == '0) begin
            state_d = ST_CLR;
            cnt_d   = cnt_load(CLR_CYCLES);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_CLR: begin
          if (cnt_q == '0) begin
            state_d = ST_SETTLE;
            cnt_d   = cnt_load(SETTLE_CYCLES);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            state_d = ST_RUN;
            ack_d   = pend_q;
            pend_d  = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (resync_req) begin
            state_d = ST_CE_OFF;
            cnt_d   = cnt_load(CE_OFF_CYCLES);
            pend_d  = 1'b1;
          end
        end
        default: begin
          state_d = ST_HALT;
          pend_d  = 1'b0;
        end
      endcase
    end
    ce_d   = (state_d == ST_RUN);
    rdy_d  = (state_d == ST_RUN);
    clr_d  = {NUM_BUFR{(state_d == ST_HALT) || (state_d == ST_CLR)}};
    busy_d = (state_d == ST_CE_OFF) || (state_d == ST_CLR) ||
             (state_d == ST_SETTLE);
  end

  assign resync_ack = ack_q;
  assign ce_out     = ce_q;
  assign bufr_clr   = clr_q;
  assign clk_ready  = rdy_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_bufmr_ce_sequencer.sv
// Scoreboard bench for bufmr_ce_sequencer.
// Expected output changes are queued by stimulus, checked by monitor.
module tb_bufmr_ce_sequencer;

  localparam int NB = 2;
`ifdef BUFMR_SEQ_LOCK_SYNC_EN
  localparam int LD = 2;
`else
  localparam int LD = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          locked = 1'b0;
  logic          resync_req = 1'b0;
  logic          resync_ack;
  logic          ce_out;
  logic [NB-1:0] bufr_clr;
  logic          clk_ready;
  logic          busy;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int         cyc;
    logic [5:0] val;
  } exp_t;

  exp_t exp_q[$];

  bufmr_ce_sequencer #(
    .CE_OFF_CYCLES (4),
    .CLR_CYCLES    (4),
    .SETTLE_CYCLES (8),
    .NUM_BUFR      (NB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .locked     (locked),
    .resync_req (resync_req),
    .resync_ack (resync_ack),
    .ce_out     (ce_out),
    .bufr_clr   (bufr_clr),
    .clk_ready  (clk_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // snapshot order: {ce, clr[1:0], ready, busy, ack}
  function automatic logic [5:0] snap();
    return {ce_out, bufr_clr, clk_ready, busy, resync_ack};
  endfunction

  task automatic push(input int c, input logic ce, input logic [1:0] clr,
                      input logic rdy, input logic bsy, input logic ack);
    exp_t e;
    e.cyc = c;
    e.val = {ce, clr, rdy, bsy, ack};
    exp_q.push_back(e);
  endtask

  // CE_OFF at s, CLR at s+4, SETTLE at s+8, RUN at s+16
  task automatic push_seq(input int s, input logic ack);
    push(s,      1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    push(s + 4,  1'b0, 2'b11, 1'b0, 1'b1, 1'b0);
    push(s + 8,  1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    push(s + 16, 1'b1, 2'b00, 1'b1, 1'b0, ack);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [5:0] got,
                       input logic [5:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // monitor: every observed output change must match the queue head
  logic [5:0] prev = 6'b011000;
  always @(negedge clk) begin
    logic [5:0] s;
    exp_t e;
    s = snap();
    if (s !== prev) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_change: got %b at cycle %0d, none queued",
                 s, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || s !== e.val) begin
          miscompares++;
          $display("FAIL out_change: got %b at cycle %0d, want %b at cycle %0d",
                   s, cyc, e.val, e.cyc);
        end
      end
      prev = s;
    end
  end

  initial begin
    #1 rst_n = 1'b0;

    // reset state
    wait_cyc(2);
    check("reset_state", snap(), 6'b011000);
    wait_cyc(3);
    rst_n = 1'b1;

    // power-up: lock at cycle 10, no ack
    push_seq(11 + LD, 1'b0);
    wait_cyc(10);
    locked = 1'b1;
    wait_cyc(20);
    check("halt_no_ack_seq", {5'b0, resync_ack}, 6'b0);

    // resync handshake: ack on RUN re-entry, one sequence
    push_seq(41, 1'b1);
    push(58, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    wait_cyc(40);
    resync_req = 1'b1;
    wait_cyc(41);
    resync_req = 1'b0;

    // lock loss on 2nd CLR cycle, then recovery with ignored request
    push(61, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    push(65, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0);
    push(67 + LD, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
    push_seq(76 + LD, 1'b0);
    wait_cyc(60);
    resync_req = 1'b1;
    wait_cyc(61);
    resync_req = 1'b0;
    wait_cyc(66);
    locked = 1'b0;
    wait_cyc(75);
    locked = 1'b1;
    wait_cyc(86 + LD);
    resync_req = 1'b1;
    wait_cyc(87 + LD);
    resync_req = 1'b0;

    // async reset in CE_OFF
    push(111, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    push(113, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
    push_seq(116 + LD, 1'b0);
    wait_cyc(110);
    resync_req = 1'b1;
    wait_cyc(111);
    resync_req = 1'b0;
    wait_cyc(112);
    check("ce_off_busy", snap(), 6'b000010);
    #1 rst_n = 1'b0;
    #1 check("async_reset", snap(), 6'b011000);
    wait_cyc(115);
    rst_n = 1'b1;

    // req still high in the ack cycle starts a second sequence
    push_seq(151, 1'b1);
    push_seq(168, 1'b1);
    push(185, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    wait_cyc(150);
    resync_req = 1'b1;
    wait_cyc(168);
    resync_req = 1'b0;

    wait_cyc(200);
    check("final_run", snap(), 6'b100100);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_changes: %0d expected changes never seen, first at cycle %0d",
               exp_q.size(), exp_q[0].cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
